shifter_r8: RTL and testbench



---
 rtl/shifter_pkg.sv | 20 ++
 rtl/shifter_r8_if.sv | 24 ++
 rtl/shifter_r8_rsh8.sv | 46 ++++
 rtl/shifter_r8.sv | 82 ++++++++
 tb/tb_shifter_r8.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/shifter_pkg.sv
// Shared constants for the registered right-shift stage.
// Opcodes and shifter mode encodings used by the datapath and its bench.
package shifter_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int SHAMT_WIDTH = 2;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_LSR  = 3'b010;
    localparam logic [2:0] OP_ASR  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;

    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,
        MODE_ASR = 2'b01,
        MODE_ROR = 2'b10
    } shift_mode_e;

endpackage

// File: rtl/shifter_r8_if.sv
// Command/result bundle for the right-shift stage.
// The master issues ops; the slave returns registered data and flags.
interface shifter_r8_if;
    import shifter_pkg::*;

    logic [2:0]             op;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [DATA_WIDTH-1:0]  d_in;
    logic [DATA_WIDTH-1:0]  d_out;
    logic                   done;
    logic                   zero;
    logic                   carry;

    modport master (
        output op, shamt, d_in,
        input  d_out, done, zero, carry
    );

    modport slave (
        input  op, shamt, d_in,
        output d_out, done, zero, carry
    );

endinterface

// File: rtl/shifter_r8_rsh8.sv
// Combinational 8-bit right shifter built from one 4:1 mux per bit.
// Fill bits above bit 7 are zero, sign copies, or wrapped low bits.
module mx4 (
    input  logic [3:0] a,
    input  logic [1:0] sel,
    output logic       y
);
    assign y = a[sel];
endmodule

module rsh8 (
    input  logic [7:0] d_in,
    input  logic [1:0] shamt,
    input  logic [1:0] mode,
    output logic [7:0] d_out,
    output logic       cout
);
    logic [2:0]  fill;
    logic [10:0] ext;

    always_comb begin
        fill = 3'b000;
        case (mode)
            2'b01:   fill = {3{d_in[7]}};
            2'b10:   fill = d_in[2:0];
            default: fill = 3'b000;
        endcase
    end

    assign ext = {fill, d_in};

    for (genvar i = 0; i < 8; i++) begin : g_bit
        mx4 u_mx (
            .a   (ext[i+3:i]),
            .sel (shamt),
            .y   (d_out[i])
        );
    end

    // Carry is the last bit to leave bit 0; none for a zero shift.
    mx4 u_cout (
        .a   ({d_in[2:0], 1'b0}),
        .sel (shamt),
        .y   (cout)
    );
endmodule

// File: rtl/shifter_r8.sv
// Registered 8-bit right-shift stage: load, LSR, ASR, ROR by 0-3.
// Data and flags update together; done pulses once per executed op.
module shifter_r8
    import shifter_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int SHW   = SHAMT_WIDTH
) (
    input  logic         clk,
    input  logic         reset_n,
    shifter_r8_if.slave  bus
);
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] sh_d;
    logic [WIDTH-1:0] nxt_d;
    logic [SHW-1:0]   amt;
    logic             sh_c;
    logic             nxt_c;
    logic             exec;
    logic             load;
    shift_mode_e      mode;
    logic             done_q;
    logic             zero_q;
    logic             carry_q;

    assign amt = bus.shamt;

    always_comb begin
        exec = 1'b0;
        load = 1'b0;
        mode = MODE_LSR;
        unique case (bus.op)
            OP_LOAD: begin
                exec = 1'b1;
                load = 1'b1;
            end
            OP_LSR: exec = 1'b1;
            OP_ASR: begin
                exec = 1'b1;
                mode = MODE_ASR;
            end
            OP_ROR: begin
                exec = 1'b1;
                mode = MODE_ROR;
            end
            default: exec = 1'b0;
        endcase
    end

    rsh8 u_rsh8 (
        .d_in  (d_q),
        .shamt (amt),
        .mode  (mode),
        .d_out (sh_d),
        .cout  (sh_c)
    );

    assign nxt_d = load ? bus.d_in : sh_d;
    assign nxt_c = load ? 1'b0 : sh_c;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            d_q     <= '0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            done_q <= exec;
            if (exec) begin
                d_q     <= nxt_d;
                carry_q <= nxt_c;
                zero_q  <= (nxt_d == '0);
            end
        end
    end

    assign bus.d_out = d_q;
    assign bus.done  = done_q;
    assign bus.zero  = zero_q;
    assign bus.carry = carry_q;

endmodule

// File: tb/tb_shifter_r8.sv
// Self-checking bench for shifter_r8: directed plan cases plus
// random ops compared against an arithmetic reference model.
module tb_shifter_r8;
    import shifter_pkg::*;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    logic [7:0] exp_d;
    logic       exp_c;
    logic       exp_z;
    logic       exp_done;

    shifter_r8_if bus ();

    shifter_r8 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: shifts by plain integer arithmetic on the byte value.
    task automatic model(input logic rst, input logic [2:0] op,
                         input int n, input logic [7:0] din);
        int v;
        int r;
        v = int'(exp_d);
        if (!rst) begin
            exp_d = 8'h00; exp_c = 1'b0; exp_z = 1'b1; exp_done = 1'b0;
            return;
        end
        if (op > 3'd4 || op == 3'd0) begin
            exp_done = 1'b0;
            return;
        end
        exp_done = 1'b1;
        if (op == 3'd1) begin
            r = int'(din);
            exp_c = 1'b0;
        end else begin
            exp_c = (n == 0) ? 1'b0 : 1'(v / (2 ** (n - 1)) % 2);
            case (op)
                3'd2: r = v / (2 ** n);
                3'd3: r = (v >= 128) ? (v - 256) : v;
                default: r = (v / (2 ** n)) + (v * (2 ** (8 - n))) % 256;
            endcase
            if (op == 3'd3) r = ((r < 0) ? ((r - (2 ** n) + 1) / (2 ** n))
                                         : (r / (2 ** n))) & 255;
        end
        exp_d = 8'(r);
        exp_z = (exp_d == 8'h00);
    endtask

    task automatic step(input logic rst, input logic [2:0] op,
                        input logic [1:0] sh, input logic [7:0] din);
        reset_n   = rst;
        bus.op    = op;
        bus.shamt = sh;
        bus.d_in  = din;
        model(rst, op, int'(sh), din);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, OP_LOAD, 2'd0, 8'hFF);
            n_checks++;
            if (bus.d_out !== 8'h00 || bus.zero !== 1'b1 ||
                bus.done !== 1'b0 || bus.carry !== 1'b0) begin
                n_fail++;
                $display("FAIL reset: got d=%h z=%b dn=%b c=%b want d=00 z=1 dn=0 c=0",
                         bus.d_out, bus.zero, bus.done, bus.carry);
            end
        end
        step(1'b1, OP_NOP, 2'd0, 8'hFF);
        n_checks++;
        if (bus.d_out !== 8'h00 || bus.done !== 1'b0 || bus.zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got d=%h dn=%b z=%b want d=00 dn=0 z=1",
                     bus.d_out, bus.done, bus.zero);
        end
    endtask

    task automatic test_directed;
        logic [2:0] t_op [13] = '{OP_LOAD, OP_LSR, OP_LOAD, OP_ASR, OP_LSR,
                                  OP_LOAD, OP_ROR, OP_ROR, OP_LOAD, OP_LSR,
                                  3'b111, 3'b101, OP_NOP};
        logic [1:0] t_sh [13] = '{0, 2, 0, 3, 3, 0, 1, 3, 0, 2, 1, 3, 2};
        logic [7:0] t_di [13] = '{8'h96, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h01,
                                  8'h00, 8'h00, 8'h03, 8'h00, 8'hAA, 8'h55, 8'h77};
        logic [7:0] t_d  [13] = '{8'h96, 8'h25, 8'h80, 8'hF0, 8'h1E, 8'h01,
                                  8'h80, 8'h10, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
        logic       t_c  [13] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1};
        logic       t_z  [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        logic       t_dn [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        for (int i = 0; i < 13; i++) begin
            step(1'b1, t_op[i], t_sh[i], t_di[i]);
            n_checks++;
            if (bus.d_out !== t_d[i] || bus.carry !== t_c[i] ||
                bus.zero !== t_z[i] || bus.done !== t_dn[i]) begin
                n_fail++;
                $display("FAIL directed[%0d] op=%b sh=%0d: got d=%h c=%b z=%b dn=%b want d=%h c=%b z=%b dn=%b",
                         i, t_op[i], t_sh[i], bus.d_out, bus.carry, bus.zero,
                         bus.done, t_d[i], t_c[i], t_z[i], t_dn[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] b_op [4] = '{OP_LOAD, OP_LSR, OP_LSR, OP_LSR};
        logic [1:0] b_sh [4] = '{0, 1, 1, 0};
        logic [7:0] b_d  [4] = '{8'hF0, 8'h78, 8'h3C, 8'h3C};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, b_op[i], b_sh[i], 8'hF0);
            n_checks++;
            if (bus.d_out !== b_d[i] || bus.done !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got d=%h dn=%b want d=%h dn=1",
                         i, bus.d_out, bus.done, b_d[i]);
            end
        end
        step(1'b0, OP_LSR, 2'd1, 8'h00);
        n_checks++;
        if (bus.d_out !== 8'h00 || bus.done !== 1'b0 || bus.zero !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_reset: got d=%h dn=%b z=%b want d=00 dn=0 z=1",
                     bus.d_out, bus.done, bus.zero);
        end
        step(1'b1, OP_NOP, 2'd0, 8'h00);
        n_checks++;
        if (bus.done !== 1'b0 || bus.d_out !== 8'h00) begin
            n_fail++;
            $display("FAIL b2b_after_reset: got d=%h dn=%b want d=00 dn=0",
                     bus.d_out, bus.done);
        end
    endtask

    task automatic test_random;
        logic       rst;
        logic [2:0] op;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 24) != 0);
            op  = ($urandom_range(0, 3) == 0) ? OP_LOAD : 3'($urandom_range(0, 7));
            step(rst, op, 2'($urandom_range(0, 3)), 8'($urandom));
            n_checks++;
            if (bus.d_out !== exp_d || bus.carry !== exp_c ||
                bus.zero !== exp_z || bus.done !== exp_done) begin
                n_fail++;
                $display("FAIL random[%0d] rst=%b op=%b sh=%0d: got d=%h c=%b z=%b dn=%b want d=%h c=%b z=%b dn=%b",
                         i, rst, op, bus.shamt, bus.d_out, bus.carry,
                         bus.zero, bus.done, exp_d, exp_c, exp_z, exp_done);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_d     = 8'h00;
        exp_c     = 1'b0;
        exp_z     = 1'b1;
        exp_done  = 1'b0;
        reset_n   = 1'b0;
        bus.op    = OP_NOP;
        bus.shamt = 2'd0;
        bus.d_in  = 8'h00;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
